// File: rtl/key_buffer_if.sv
// rtl/key_buffer_if.sv - scan-code input, pop request and key FIFO status bundle
interface key_buffer_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       clean_key_buffer;
  logic [7:0] pressed_key;
  logic [4:0] key_count;
  logic       overflow;

  modport master (
    output scan_valid, scan_code, clean_key_buffer,
    input  pressed_key, key_count, overflow
  );

  modport slave (
    input  scan_valid, scan_code, clean_key_buffer,
    output pressed_key, key_count, overflow
  );
endinterface

// File: rtl/key_buffer.sv
// rtl/key_buffer.sv - PS/2 set-2 make-code decoder feeding a circular key FIFO
// Releases and keyboard status bytes are dropped; E0-prefixed makes are tagged with bit 7.
module key_buffer #(
  parameter int DEPTH = 8
) (
  input logic       CLK,
  input logic       reset,
  key_buffer_if.slave kb
);
  localparam int         PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FULL_COUNT = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t           state, state_next;
  logic             push_req;
  logic [7:0]       push_code;
  logic             status_byte;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [4:0]       count;
  logic             ovf;
  logic             full, do_pop, do_push;

  assign status_byte = kb.scan_code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  always_ff @(posedge CLK) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    push_req   = 1'b0;
    push_code  = kb.scan_code;
    if (kb.scan_valid) begin
      unique case (state)
        IDLE: begin
          if (kb.scan_code == 8'hF0)      state_next = BRK;
          else if (kb.scan_code == 8'hE0) state_next = EXT;
          else if (!status_byte)          push_req   = 1'b1;
        end
        BRK: state_next = IDLE;
        EXT: begin
          // Repeated E0 prefixes are tolerated; the sequence stays extended.
          if (kb.scan_code == 8'hF0) state_next = EXT_BRK;
          else if (kb.scan_code != 8'hE0) begin
            push_req   = 1'b1;
            push_code  = {1'b1, kb.scan_code[6:0]};
            state_next = IDLE;
          end
        end
        EXT_BRK: state_next = IDLE;
      endcase
    end
  end

  assign full    = (count == FULL_COUNT);
  assign do_pop  = kb.clean_key_buffer && (count != 5'd0);
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (reset && do_push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 5'd0;
      ovf    <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (push_req && !do_push) ovf <= 1'b1;
    end
  end

  assign kb.pressed_key = (count != 5'd0) ? mem[rd_ptr] : 8'h00;
  assign kb.key_count   = count;
  assign kb.overflow    = ovf;
endmodule

// File: doc/key_buffer.md
KEY_BUFFER -- requirements
Module: key_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, default 8, number of FIFO entries; a power of two, 2..16.
REQ-002 SHALL have port: CLK  input  1  CPU clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: scan_valid  input  1  one-cycle strobe; scan_code holds a new PS/2 byte from the keyboard receiver.
REQ-005 SHALL have port: scan_code  input  8  received PS/2 set-2 byte; sampled only when scan_valid=1.
REQ-006 SHALL have port: clean_key_buffer  input  1  pop request from the memory-mapped keyboard register; one pop per high cycle.
REQ-007 SHALL have port: pressed_key  output  8  FIFO head key code; 8'h00 when empty.
REQ-008 SHALL have port: key_count  output  5  number of valid entries, 0..DEPTH.
REQ-009 SHALL have port: overflow  output  1  sticky flag; a key was dropped because the FIFO was full.

Function
REQ-010 SHALL decode the byte stream with FSM states IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
REQ-011 IDLE: 8'hF0 -> BRK; 8'hE0 -> EXT; 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF -> discard, stay IDLE; any other byte -> push byte, stay IDLE.
REQ-012 BRK: any byte -> discard (key release), -> IDLE.
REQ-013 EXT: 8'hF0 -> EXT_BRK; 8'hE0 -> stay EXT; any other byte -> push {1'b1, byte[6:0]}, -> IDLE.
REQ-014 EXT_BRK: any byte -> discard, -> IDLE.
REQ-015 FSM SHALL advance only on cycles with scan_valid=1 and SHALL hold state otherwise.
REQ-016 SHALL implement a circular FIFO of DEPTH 8-bit entries with read pointer, write pointer and count; pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 A push SHALL take effect at the same edge as the accepting scan_valid; the pushed code SHALL appear on pressed_key the next cycle if the FIFO was empty.
REQ-018 pressed_key SHALL be the registered or combinational head entry when key_count>0, else 8'h00; it SHALL have no extra latency beyond REQ-017.
REQ-019 A pop (clean_key_buffer=1, key_count>0) SHALL advance the read pointer; the next entry, or 8'h00, SHALL appear the following cycle.
REQ-020 A pop with key_count=0 SHALL be ignored, with no pointer or count change.
REQ-021 A push with key_count=DEPTH SHALL be dropped, SHALL set overflow=1, and SHALL leave FIFO contents and pointers unchanged, unless a pop occurs in the same cycle (REQ-022).
REQ-022 Simultaneous push and pop SHALL both take effect; key_count SHALL be unchanged, including when full (the pop frees a slot, so the push is accepted and overflow stays unchanged) and when empty (the pop is ignored; the push gives count=1).
REQ-023 overflow SHALL remain 1 until reset; pops SHALL NOT clear it.
REQ-024 Typematic repeats SHALL NOT be filtered; each repeated make code SHALL be pushed.
REQ-025 key_count SHALL equal pushes accepted minus pops accepted since reset, and SHALL never exceed DEPTH.

Reset
REQ-026 When reset=0 at a clock edge, FSM -> IDLE; pointers and key_count -> 0; overflow -> 0; pressed_key -> 8'h00.
REQ-027 Reset SHALL override scan_valid and clean_key_buffer in the same cycle; a partial sequence (F0 or E0 already received) SHALL be abandoned.
REQ-028 FIFO storage contents need not be reset.

Verification
REQ-029 Scenario: bytes 1C, F0, 1C -> exactly one push; pressed_key=8'h1C, key_count=1.
REQ-030 Scenario: bytes E0, 75 then E0, F0, 75 -> one push; pressed_key=8'hF5.
REQ-031 Scenario: 9 make codes 15,1D,24,2D,2C,35,3C,43 then 44 with DEPTH=8 -> key_count=8, overflow=1; 8 pops yield 15..43 in order, and 44 is never output.
REQ-032 Scenario: FIFO full, scan_valid with 4D and clean_key_buffer in the same cycle -> key_count stays 8, overflow stays 0, 4D is the last entry.
REQ-033 Scenario: pop on empty FIFO -> key_count=0, pressed_key=8'h00; then AA, FA -> nothing pushed.
REQ-034 Scenario: byte F0, then reset=0 for one cycle, then byte 1C -> 1C is pushed (FSM was back in IDLE); all outputs are zero during and just after reset.
